// File: rtl/spi_slave.sv
// SPI mode-0 slave (MSB first) oversampled in the clk_i domain; SYNC_STAGES must be >= 2.
// Optional macro SPI_MISO_TRISTATE_EN floats spi_miso_o while chip select is inactive.
module spi_slave #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DATA_W      = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              spi_sck_i,
    input  logic              spi_cs_i,
    input  logic              spi_mosi_i,
    output logic              spi_miso_o,
    output logic [DATA_W-1:0] writeGlu,
    input  logic [DATA_W-1:0] readGlu,
    output logic              newOctet
);

    localparam int unsigned CntW = $clog2(DATA_W + 1);
    localparam logic [CntW-1:0] LastBit = CntW'(DATA_W - 1);

    logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sck_s, cs_s, mosi_s;
    logic                   sck_dly_q, cs_dly_q, mosi_dly_q;
    logic                   sck_rise_q, sck_fall_q, cs_fall_q;

    logic [CntW-1:0]   cnt_q, cnt_d;
    // Only DATA_W-1 bits need storing; the last bit goes straight into writeGlu.
    logic [DATA_W-2:0] rx_q, rx_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0] wr_q, wr_d;
    logic              new_q, new_d;

    assign sck_s  = sck_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // Edge pulses are registered so they line up with cs_dly_q and mosi_dly_q.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sck_sync_q  <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sck_dly_q   <= 1'b0;
            cs_dly_q    <= 1'b1;
            mosi_dly_q  <= 1'b0;
            sck_rise_q  <= 1'b0;
            sck_fall_q  <= 1'b0;
            cs_fall_q   <= 1'b0;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck_i};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
            sck_dly_q   <= sck_s;
            cs_dly_q    <= cs_s;
            mosi_dly_q  <= mosi_s;
            sck_rise_q  <= sck_s & ~sck_dly_q;
            sck_fall_q  <= ~sck_s & sck_dly_q;
            cs_fall_q   <= ~cs_s & cs_dly_q;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        rx_d  = rx_q;
        tx_d  = tx_q;
        wr_d  = wr_q;
        new_d = 1'b0;
        if (cs_dly_q) begin
            cnt_d = '0;
            rx_d  = '0;
        end else begin
            if (cs_fall_q) begin
                tx_d = readGlu;
            end
            if (sck_rise_q) begin
                rx_d = {rx_q[DATA_W-3:0], mosi_dly_q};
                if (cnt_q == LastBit) begin
                    wr_d  = {rx_q, mosi_dly_q};
                    new_d = 1'b1;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            if (sck_fall_q) begin
                // A zero count here means an octet just completed: fetch the next one.
                if (cnt_q == '0) begin
                    tx_d = readGlu;
                end else begin
                    tx_d = tx_q << 1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            rx_q  <= '0;
            tx_q  <= '0;
            wr_q  <= '0;
            new_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            rx_q  <= rx_d;
            tx_q  <= tx_d;
            wr_q  <= wr_d;
            new_q <= new_d;
        end
    end

    assign writeGlu = wr_q;
    assign newOctet = new_q;

`ifdef SPI_MISO_TRISTATE_EN
    assign spi_miso_o = cs_dly_q ? 1'bz : tx_q[DATA_W-1];
`else
    assign spi_miso_o = ~cs_dly_q & tx_q[DATA_W-1];
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: directed vector table, hand sequences and random frames vs a byte-level model.
`timescale 1ns/1ps
module tb_spi_slave;

    localparam int unsigned SyncStages = 2;
    localparam int unsigned DataW      = 8;
    localparam int          Lat        = SyncStages + 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       sck;
    logic       cs;
    logic       mosi;
    logic       miso;
    logic [7:0] writeGlu;
    logic [7:0] readGlu;
    logic       newOctet;

    always #5 clk = ~clk;

    spi_slave #(
        .SYNC_STAGES(SyncStages),
        .DATA_W     (DataW)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .spi_sck_i (sck),
        .spi_cs_i  (cs),
        .spi_mosi_i(mosi),
        .spi_miso_o(miso),
        .writeGlu  (writeGlu),
        .readGlu   (readGlu),
        .newOctet  (newOctet)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int pulses = 0;
    int last_pulse_cyc = -1000;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (newOctet === 1'b1) begin
            pulses++;
            last_pulse_cyc = cyc;
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Master side of one byte: MOSI set half a period before each rise, MISO sampled at the rise.
    task automatic send_byte(input logic [7:0] data, input int nbits, input int half,
                             input logic [7:0] next_rd, output logic [7:0] miso_bits,
                             output int rise_cyc);
        miso_bits = 8'h00;
        rise_cyc  = 0;
        for (int i = 0; i < nbits; i++) begin
            mosi = data[7-i];
            tick(half);
            miso_bits = {miso_bits[6:0], miso};
            sck = 1'b1;
            rise_cyc = cyc;
            tick(half);
            if (i == 0) readGlu = next_rd;
            sck = 1'b0;
        end
    endtask

    typedef struct {
        logic [7:0] mosi_byte;
        logic [7:0] rd;
        int         nbits;
        logic [7:0] exp_wr;
        int         exp_pulses;
        logic [7:0] exp_miso;
    } vec_t;

    vec_t       vecs[5];
    logic [7:0] exp_wr;
    logic [7:0] mb;
    int         rc;
    int         p0;

    initial begin
        vecs[0] = '{8'hDD, 8'h00, 8, 8'hDD, 1, 8'h00};
        vecs[1] = '{8'h3F, 8'h00, 8, 8'h3F, 1, 8'h00};
        vecs[2] = '{8'h3C, 8'hA5, 8, 8'h3C, 1, 8'hA5};
        vecs[3] = '{8'hFF, 8'h96, 5, 8'h3C, 0, 8'h12};
        vecs[4] = '{8'h81, 8'h81, 8, 8'h81, 1, 8'h81};

        rst = 1'b1; cs = 1'b1; sck = 1'b0; mosi = 1'b0; readGlu = 8'h00;
        tick(3);
        check("reset writeGlu", writeGlu, 8'h00);
        check("reset newOctet", {7'b0, newOctet}, 8'h00);
`ifdef SPI_MISO_TRISTATE_EN
        check("reset miso", {7'b0, miso}, {7'b0, 1'bz});
`else
        check("reset miso", {7'b0, miso}, 8'h00);
`endif
        rst = 1'b0;
        tick(10);

        for (int i = 0; i < 5; i++) begin
            readGlu = vecs[i].rd;
            p0 = pulses;
            cs = 1'b0;
            send_byte(vecs[i].mosi_byte, vecs[i].nbits, 13, vecs[i].rd, mb, rc);
            if (vecs[i].nbits == 8)
                check($sformatf("vec%0d latency", i), 8'(last_pulse_cyc - rc), 8'(Lat));
            tick(5);
            cs = 1'b1;
            tick(50);
            check($sformatf("vec%0d writeGlu", i), writeGlu, vecs[i].exp_wr);
            check($sformatf("vec%0d pulses", i), 8'(pulses - p0), 8'(vecs[i].exp_pulses));
            check($sformatf("vec%0d miso", i), mb, vecs[i].exp_miso);
`ifdef SPI_MISO_TRISTATE_EN
            check($sformatf("vec%0d idle miso", i), {7'b0, miso}, {7'b0, 1'bz});
`else
            check($sformatf("vec%0d idle miso", i), {7'b0, miso}, 8'h00);
`endif
        end
        exp_wr = 8'h81;

        // Back-to-back octets in one CS window; readGlu swapped mid byte 1.
        readGlu = 8'hC3;
        p0 = pulses;
        cs = 1'b0;
        send_byte(8'h11, 8, 13, 8'h5A, mb, rc);
        check("b2b byte1 miso", mb, 8'hC3);
        send_byte(8'h22, 8, 13, 8'h00, mb, rc);
        check("b2b byte2 miso", mb, 8'h5A);
        tick(5);
        cs = 1'b1;
        tick(30);
        check("b2b writeGlu", writeGlu, 8'h22);
        check("b2b pulses", 8'(pulses - p0), 8'd2);
        exp_wr = 8'h22;

        // CS fall and first SCK rise seen in the same cycle.
        p0 = pulses;
        mosi = 1'b1;
        tick(13);
        cs = 1'b0;
        sck = 1'b1;
        tick(13);
        sck = 1'b0;
        send_byte(8'h68, 7, 13, 8'h00, mb, rc);
        tick(5);
        cs = 1'b1;
        tick(30);
        check("same-cycle writeGlu", writeGlu, 8'hB4);
        check("same-cycle pulses", 8'(pulses - p0), 8'd1);
        exp_wr = 8'hB4;

        // Reset after bit 4, then a full frame.
        cs = 1'b0;
        send_byte(8'hF0, 4, 13, 8'h00, mb, rc);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("midreset writeGlu", writeGlu, 8'h00);
        check("midreset newOctet", {7'b0, newOctet}, 8'h00);
        cs = 1'b1;
        tick(30);
        p0 = pulses;
        cs = 1'b0;
        send_byte(8'h7E, 8, 13, 8'h00, mb, rc);
        tick(5);
        cs = 1'b1;
        tick(30);
        check("postreset writeGlu", writeGlu, 8'h7E);
        check("postreset pulses", 8'(pulses - p0), 8'd1);
        exp_wr = 8'h7E;

        // SCK toggling while deselected must be ignored.
        p0 = pulses;
        for (int i = 0; i < 8; i++) begin
            mosi = 1'($urandom);
            tick(8);
            sck = 1'b1;
            tick(8);
            sck = 1'b0;
        end
        tick(10);
        check("idle-sck writeGlu", writeGlu, exp_wr);
        check("idle-sck pulses", 8'(pulses - p0), 8'd0);

        // Random frames against a byte-level model.
        for (int f = 0; f < 20; f++) begin
            logic [7:0] mos[3];
            logic [7:0] rds[3];
            int nbytes, half, nb, exp_p;
            nbytes = $urandom_range(1, 3);
            half   = $urandom_range(6, 14);
            for (int k = 0; k < 3; k++) begin
                mos[k] = 8'($urandom);
                rds[k] = 8'($urandom);
            end
            exp_p = 0;
            p0 = pulses;
            readGlu = rds[0];
            cs = 1'b0;
            for (int k = 0; k < nbytes; k++) begin
                nb = 8;
                if (k == nbytes - 1 && $urandom_range(0, 3) == 0) nb = $urandom_range(1, 7);
                send_byte(mos[k], nb, half, (k + 1 < nbytes) ? rds[k+1] : 8'($urandom), mb, rc);
                check($sformatf("rand%0d.%0d miso", f, k), mb, rds[k] >> (8 - nb));
                if (nb == 8) begin
                    exp_wr = mos[k];
                    exp_p++;
                    check($sformatf("rand%0d.%0d latency", f, k), 8'(last_pulse_cyc - rc),
                          8'(Lat));
                end
            end
            tick(5);
            cs = 1'b1;
            tick(20 + $urandom_range(0, 30));
            check($sformatf("rand%0d writeGlu", f), writeGlu, exp_wr);
            check($sformatf("rand%0d pulses", f), 8'(pulses - p0), 8'(exp_p));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
